// File: rtl/shift_arith_pkg.sv
// Shared definitions for the shift-based ALU engines (divider and multiplier).
package shift_arith_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/shl1_stage.sv
// One-bit left-shift register with parallel load, shift enable and zero fill.
module shl1_stage #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             en,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (load) begin
            q <= load_val;
        end else if (en) begin
            // MSB falls off the top; a zero enters at bit 0
            q <= {q[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/shr1_stage.sv
// One-bit right-shift register with parallel load and zero fill; presents its LSB serially.
module shr1_stage #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             en,
    input  logic [WIDTH-1:0] load_val,
    output logic             lsb
);

    logic [WIDTH-1:0] q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (load) begin
            q <= load_val;
        end else if (en) begin
            q <= {1'b0, q[WIDTH-1:1]};
        end
    end

    assign lsb = q[0];

endmodule

// File: rtl/shift_multiplier.sv
// Sequential shift-and-add unsigned multiplier: one multiplier bit per clock,
// WIDTH iterations, registered 2*WIDTH-bit product with a one-cycle done pulse.
module shift_multiplier
    import shift_arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t             state;
    state_t             next_state;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_next;
    logic [2*WIDTH-1:0] mcand;
    logic               mplier_lsb;
    logic               load;
    logic               shift_en;
    logic               last_iter;

    assign load      = (state == IDLE) && start;
    assign shift_en  = (state == RUN);
    assign last_iter = (cnt == CW'(WIDTH - 1));

    shl1_stage #(.WIDTH(2 * WIDTH)) u_mcand (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .en       (shift_en),
        .load_val ({{WIDTH{1'b0}}, multiplicand}),
        .q        (mcand)
    );

    shr1_stage #(.WIDTH(WIDTH)) u_mplier (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .en       (shift_en),
        .load_val (multiplier),
        .lsb      (mplier_lsb)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (start) next_state = RUN;
            RUN:     if (last_iter) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // acc is 2*WIDTH wide, so the sum never exceeds (2^WIDTH-1)^2 and cannot wrap
    always_comb begin
        acc_next = acc;
        if (mplier_lsb) begin
            acc_next = acc + mcand;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            cnt     <= '0;
            product <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            busy <= (next_state == RUN);
            done <= (next_state == DONE);
            if (load) begin
                acc <= '0;
                cnt <= '0;
            end else if (shift_en) begin
                acc <= acc_next;
                cnt <= cnt + CW'(1);
                if (last_iter) begin
                    product <= acc_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_shift_multiplier.sv
// Self-checking bench for shift_multiplier at WIDTH=8 and WIDTH=4 against A*B.
module tb_shift_multiplier;

    logic        clk;
    logic        rst_n;
    logic        s8, s4;
    logic [7:0]  a8, b8;
    logic [3:0]  a4, b4;
    logic        busy8, done8, busy4, done4;
    logic [15:0] p8;
    logic [7:0]  p4;

    int n_chk;
    int n_fail;

    shift_multiplier #(.WIDTH(8)) u_dut8 (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (s8),
        .multiplicand (a8),
        .multiplier   (b8),
        .busy         (busy8),
        .done         (done8),
        .product      (p8)
    );

    shift_multiplier #(.WIDTH(4)) u_dut4 (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (s4),
        .multiplicand (a4),
        .multiplier   (b4),
        .busy         (busy4),
        .done         (done4),
        .product      (p4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic drive(input int w, input logic st, input int a, input int b);
        if (w == 8) begin
            s8 = st; a8 = a[7:0]; b8 = b[7:0];
        end else begin
            s4 = st; a4 = a[3:0]; b4 = b[3:0];
        end
    endtask

    function automatic logic busy_of(input int w);
        return (w == 8) ? busy8 : busy4;
    endfunction

    function automatic logic done_of(input int w);
        return (w == 8) ? done8 : done4;
    endfunction

    function automatic int prod_of(input int w);
        return (w == 8) ? int'(p8) : int'(p4);
    endfunction

    // One full transaction; operands are scrambled every cycle after the accept edge
    task automatic do_mul(input int w, input int a, input int b, input string tag);
        int   mask;
        int   exp_p;
        int   lat;
        int   busy_cycles;
        logic dn;
        mask  = (1 << w) - 1;
        exp_p = (a & mask) * (b & mask);
        @(negedge clk);
        drive(w, 1'b1, a, b);
        @(posedge clk);
        #1;
        drive(w, 1'b0, $urandom, $urandom);
        busy_cycles = busy_of(w) ? 1 : 0;
        lat = 0;
        dn  = 1'b0;
        while (!dn && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            dn = done_of(w);
            if (!dn) begin
                if (busy_of(w)) busy_cycles++;
                drive(w, 1'b0, $urandom, $urandom);
            end
        end
        check_eq({tag, "_latency"}, lat, w);
        check_eq({tag, "_busy_cycles"}, busy_cycles, w);
        check_eq({tag, "_product"}, prod_of(w), exp_p);
        check_eq({tag, "_busy_at_done"}, busy_of(w), 1'b0);
        @(posedge clk);
        #1;
        check_eq({tag, "_done_one_cycle"}, done_of(w), 1'b0);
        check_eq({tag, "_product_held"}, prod_of(w), exp_p);
    endtask

    initial begin
        int done_idx[$];
        int overlap;
        int dbl;
        int busy_cnt;
        int bad_prod;
        int spurious;
        logic prev_done;

        n_chk  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        s8 = 1'b0; a8 = '0; b8 = '0;
        s4 = 1'b0; a4 = '0; b4 = '0;

        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_busy8", busy8, 1'b0);
        check_eq("rst_done8", done8, 1'b0);
        check_eq("rst_prod8", p8, 16'd0);
        check_eq("rst_busy4", busy4, 1'b0);
        check_eq("rst_done4", done4, 1'b0);
        check_eq("rst_prod4", p4, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;

        do_mul(8, 13, 11, "m13x11");
        repeat (3) @(posedge clk);
        #1;
        check_eq("m13x11_held_idle", p8, 16'd143);
        do_mul(8, 255, 255, "m255x255");
        do_mul(8, 0, 200, "m0x200");
        do_mul(8, 200, 0, "m200x0");

        // start held high: accepts land every WIDTH+2 edges
        overlap = 0; dbl = 0; busy_cnt = 0; bad_prod = 0; prev_done = 1'b0;
        @(negedge clk);
        drive(8, 1'b1, 3, 5);
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (i == 30) s8 = 1'b0;
            if (busy8 && done8) overlap++;
            if (done8 && prev_done) dbl++;
            if (busy8) busy_cnt++;
            if (done8) begin
                done_idx.push_back(i);
                if (p8 != 16'd15) bad_prod++;
            end
            prev_done = done8;
        end
        check_eq("held_done_count", done_idx.size(), 4);
        if (done_idx.size() == 4) begin
            check_eq("held_first_done", done_idx[0], 8);
            for (int k = 1; k < 4; k++)
                check_eq("held_done_spacing", done_idx[k] - done_idx[k-1], 10);
        end
        check_eq("held_busy_done_overlap", overlap, 0);
        check_eq("held_done_back_to_back", dbl, 0);
        check_eq("held_busy_cycles", busy_cnt, 32);
        check_eq("held_products", bad_prod, 0);

        do_mul(8, 7, 9, "m7x9_scrambled");

        // reset in the middle of an iteration sequence
        @(negedge clk);
        drive(8, 1'b1, 100, 100);
        @(posedge clk);
        #1;
        s8 = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("midrst_busy", busy8, 1'b0);
        check_eq("midrst_done", done8, 1'b0);
        check_eq("midrst_product", p8, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        spurious = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (done8 || busy8) spurious++;
        end
        check_eq("midrst_no_done", spurious, 0);
        do_mul(8, 2, 3, "m2x3_after_rst");

        do_mul(4, 15, 15, "w4_15x15");
        for (int i = 0; i < 1000; i++) do_mul(8, $urandom, $urandom, "rnd8");
        for (int i = 0; i < 1000; i++) do_mul(4, $urandom, $urandom, "rnd4");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/shift_multiplier.md
# shift_multiplier

Sequential shift-and-add unsigned multiplier, the multiply-side counterpart of the team's shift-divider datapath. It accepts two WIDTH-bit operands on a start pulse and iterates one bit per clock, shifting the multiplicand left and the multiplier right. After WIDTH iterations it presents a 2*WIDTH-bit product with a one-cycle done pulse. It sits beside the divider as the second arithmetic engine of the shift-based ALU.

## Interface
- WIDTH, 8, operand width in bits; must be ≥ 2.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request pulse; sampled only in IDLE.
- multiplicand  input  WIDTH  operand A, unsigned; sampled with start.
- multiplier  input  WIDTH  operand B, unsigned; sampled with start.
- busy  output  1  high while iterating (RUN state).
- done  output  1  single-cycle pulse; product valid.
- product  output  2*WIDTH  A*B result, registered; held until the next completion.

## Operation
- States:
  - IDLE: start=1 → RUN. Latch A into mcand (zero-extended to 2*WIDTH), B into mplier. Clear acc and cnt.
  - RUN: each cycle, if mplier[0]=1 then acc ← acc + mcand. Then mcand ← mcand<<1, mplier ← mplier>>1 with a 0 shifted into the MSB, and cnt ← cnt+1. On the iteration where cnt = WIDTH-1 → DONE, and product ← final acc.
  - DONE: done=1 for exactly one cycle → IDLE unconditionally.
- Counter width is $clog2(WIDTH). The iteration count is fixed at WIDTH. There is no early exit when mplier becomes 0.
- Arithmetic:
  - acc is 2*WIDTH bits and cannot overflow, because the maximum product is (2^WIDTH-1)^2.
  - The shifted-out MSB of mcand is discarded; it is always 0 within WIDTH shifts.
- start is ignored in RUN and DONE. There is no queuing, and operand inputs are don't-care outside the IDLE accept cycle.
- Operand changes during RUN have no effect.
- Reset, asynchronous and at any time including mid-RUN: state ← IDLE, busy=0, done=0, product=0, acc/mcand/mplier/cnt=0. Any in-flight operation is discarded with no done pulse.

## Timing
- Accept edge E: start=1 in IDLE. busy=1 from E through E+WIDTH-1, i.e. WIDTH cycles.
- Edge E+WIDTH: product updates, done=1 and busy=0 for the following cycle.
- Edge E+WIDTH+1: done=0, state IDLE. The earliest next accept is edge E+WIDTH+2, which gives a throughput of one result per WIDTH+2 cycles.
- busy and done are never high together. done is never high for two consecutive cycles.
- Reset values of all outputs: busy=0, done=0, product=0.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Structure
- Shared package shift_arith_pkg:
  - state enum {IDLE, RUN, DONE}.
  - default WIDTH constant.
  - shared with the divider control FSM.
- Sub-module shl1_stage: WIDTH-generic one-bit left-shift register stage with enable and zero fill, mirroring the divider's right-shift stage. Instantiated for mcand. mplier uses the divider's existing right-shift stage.
- Only the top level holds the FSM, counter, adder and product register.

## Test plan
- A=13, B=11, one start pulse → busy high for 8 cycles, then done pulses once with product=143, held afterward.
- A=255, B=255 → product=65025 (0xFE01). A=0, B=200 → 0. A=200, B=0 → 0. All three complete in 8 cycles.
- Start held high continuously with A=3, B=5 → results 15 at done, next accept 2 cycles after each accept+8. Check the busy/done spacing and confirm no start is accepted in RUN or DONE.
- Change A/B every cycle during RUN after accepting A=7, B=9 → product=63, unaffected.
- Assert rst_n=0 mid-RUN (cnt=4) → busy/done/product go to 0 immediately, no done pulse. A subsequent start with A=2, B=3 → 6.
- Random sweep: 1000 operand pairs, with WIDTH=8 and also WIDTH=4 → every product equals A*B and latency is exactly WIDTH cycles.
